// File: rtl/ahb_mem_responder.sv
// AHB-Lite memory responder: word-wide backing store for I-cache refills and preload writes.
// Latency: read data valid WAIT_STATES+1 cycles after the address phase is accepted.
// Backpressure: hreadyout low during wait states and the first ERROR cycle; the bus holds the next address.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   hsel, haddr, htrans,
//   hwrite, hsize        AHB-Lite address phase (sampled when hready_in is high)
//   hwdata               write data, sampled at the end of the write's DATA cycle
//   hready_in            bus-wide hready
//   hrdata               registered read data
//   hreadyout, hresp     data-phase completion and OKAY/ERROR response
module ahb_mem_responder #(
    parameter int          MEM_DEPTH   = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int          IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'd4;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               write_q, write_d;
    logic [31:0]        hrdata_q, hrdata_d;

    logic [31:0]        mem [MEM_DEPTH];

    // Address-phase decode
    logic               trans_active;
    logic               accept;
    logic               can_accept;
    logic [31:0]        offset;
    logic [IDX_W-1:0]   new_idx;
    logic               addr_err;
    logic               fwd_hit;

    assign trans_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign accept       = hsel && trans_active && hready_in;
    // Only states that present hreadyout=1 can take a new address phase.
    assign can_accept   = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);

    assign offset  = haddr - BASE_ADDR;
    assign new_idx = offset[IDX_W+1:2];
    // BASE_ADDR is word aligned, so offset[1:0] equals haddr[1:0].
    assign addr_err = (offset[1:0] != 2'b00) ||
                      (hsize != HSIZE_WORD) ||
                      ({1'b0, offset} >= MEM_BYTES);

    // A write completing this edge to the word a zero-wait read is fetching:
    // the array still holds the old value, so bypass hwdata into hrdata.
    assign fwd_hit = (state_q == ST_DATA) && write_q && (idx_q == new_idx);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        hrdata_d = hrdata_q;

        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) begin
                    idx_d   = new_idx;
                    write_d = hwrite;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_DATA;
                        if (!hwrite) begin
                            hrdata_d = fwd_hit ? hwdata : mem[new_idx];
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                    if (!write_q) begin
                        hrdata_d = mem[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state_q)
            ST_WAIT: hreadyout = 1'b0;
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    assign hrdata = hrdata_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            hrdata_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Array is not reset. Reset forces state_q out of DATA asynchronously,
    // which is what drops an in-flight write.
    always_ff @(posedge clk) begin
        if ((state_q == ST_DATA) && write_q) begin
            mem[idx_q] <= hwdata;
        end
    end

endmodule
